pixel_dispatch_ctrl: RTL and testbench

// Frame scan scheduler between the zoom unit and the Mandelbrot iteration engines.
// - On frame_go, latches the current view: start coordinate of pixel (0,0) and zoom level.
// - Raster-scans H_RES x V_RES pixels and computes each pixel's complex coordinate (c_re, c_im) incrementally.
// - Hands each pixel to one of NUM_ENG engines using round-robin arbitration, at most one pixel per cycle.

---
 rtl/pixel_dispatch_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pixel_dispatch_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_dispatch_ctrl.sv
// Frame scan scheduler: raster-scans H_RES x V_RES pixels and hands each one to NUM_ENG engines round-robin.
// Optional macro FRAME_RESTART_EN: frame_go during a scan aborts it and reloads the view.
module pixel_dispatch_ctrl #(
  parameter int           Q       = 21,
  parameter int           N       = 32,
  parameter int           NUM_ENG = 4,
  parameter int           H_RES   = 640,
  parameter int           V_RES   = 480,
  // 2^-8 in the Q-format, i.e. 32'h00002000 for Q=21
  parameter logic [N-1:0] STEP0   = N'(1) << (Q - 8)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_go,
  input  logic [N-1:0]       start_X,
  input  logic [N-1:0]       start_Y,
  input  logic [1:0]         zoom_level,
  input  logic [NUM_ENG-1:0] eng_ready,
  output logic [NUM_ENG-1:0] eng_valid,
  output logic [15:0]        pix_X,
  output logic [15:0]        pix_Y,
  output logic [N-1:0]       c_re,
  output logic [N-1:0]       c_im,
  output logic               busy,
  output logic               frame_done
);

  localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_t;

  state_t              state_q;
  logic [PTR_W-1:0]    rr_q;
  logic [PTR_W-1:0]    rr_d;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W:0]      rr_sum;
  logic                grant_vld;
  logic                xfer;
  logic                restart;
  logic                eol;
  logic                last_pix;
  logic [15:0]         pix_x_q;
  logic [15:0]         pix_y_q;
  logic [15:0]         pix_x_d;
  logic [15:0]         pix_y_d;
  logic signed [N-1:0] start_x_q;
  logic signed [N-1:0] step_q;
  logic signed [N-1:0] c_re_q;
  logic signed [N-1:0] c_im_q;
  logic signed [N-1:0] c_re_d;
  logic signed [N-1:0] c_im_d;
  logic                busy_q;
  logic                done_q;

  function automatic logic signed [N-1:0] zoom_step(input logic [1:0] zoom);
    return $signed(STEP0) >>> zoom;
  endfunction

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    // Walk offsets farthest-first so the ready engine closest to rr_q wins.
    for (int k = NUM_ENG - 1; k >= 0; k--) begin
      rr_sum = {1'b0, rr_q} + (PTR_W + 1)'(k);
      if (rr_sum >= (PTR_W + 1)'(NUM_ENG)) begin
        rr_sum = rr_sum - (PTR_W + 1)'(NUM_ENG);
      end
      if (eng_ready[rr_sum[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = rr_sum[PTR_W-1:0];
      end
    end
  end

  assign xfer = (state_q == ISSUE) && grant_vld;
  assign rr_d = (grant_idx == PTR_W'(NUM_ENG - 1)) ? '0 : grant_idx + 1'b1;

`ifdef FRAME_RESTART_EN
  assign restart = (state_q == ISSUE) && frame_go;
`else
  assign restart = 1'b0;
`endif

  always_comb begin
    eol      = (pix_x_q == 16'(H_RES - 1));
    last_pix = eol && (pix_y_q == 16'(V_RES - 1));
    if (eol) begin
      // Imaginary axis points up the screen, so each new line steps c_im down.
      pix_x_d = '0;
      pix_y_d = pix_y_q + 16'd1;
      c_re_d  = start_x_q;
      c_im_d  = c_im_q - step_q;
    end else begin
      pix_x_d = pix_x_q + 16'd1;
      pix_y_d = pix_y_q;
      c_re_d  = c_re_q + step_q;
      c_im_d  = c_im_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      start_x_q <= '0;
      step_q    <= '0;
      c_re_q    <= '0;
      c_im_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_go) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          start_x_q <= $signed(start_X);
          step_q    <= zoom_step(zoom_level);
          pix_x_q   <= '0;
          pix_y_q   <= '0;
          c_re_q    <= $signed(start_X);
          c_im_q    <= $signed(start_Y);
          state_q   <= ISSUE;
        end
        ISSUE: begin
          if (xfer) begin
            rr_q <= rr_d;
          end
          // The final pixel leaves its coordinates on the outputs instead of wrapping past the frame.
          if (xfer && !last_pix) begin
            pix_x_q <= pix_x_d;
            pix_y_q <= pix_y_d;
            c_re_q  <= c_re_d;
            c_im_q  <= c_im_d;
          end
          if (restart) begin
            state_q <= LOAD;
          end else if (xfer && last_pix) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign eng_valid  = xfer ? (NUM_ENG'(1) << grant_idx) : '0;
  assign pix_X      = pix_x_q;
  assign pix_Y      = pix_y_q;
  assign c_re       = c_re_q;
  assign c_im       = c_im_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_dispatch_ctrl.sv
// Directed bench for pixel_dispatch_ctrl on a 4x3 frame with 4 engines; a frame-level model is checked every cycle.
module tb_pixel_dispatch_ctrl;

  localparam int NE   = 4;
  localparam int HR   = 4;
  localparam int VR   = 3;
  localparam int NPIX = HR * VR;
`ifdef FRAME_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_go;
  logic [31:0] start_X;
  logic [31:0] start_Y;
  logic [1:0]  zoom_level;
  logic [3:0]  eng_ready;
  logic [3:0]  eng_valid;
  logic [15:0] pix_X;
  logic [15:0] pix_Y;
  logic [31:0] c_re;
  logic [31:0] c_im;
  logic        busy;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int test_id = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pixel_dispatch_ctrl #(
    .NUM_ENG (NE),
    .H_RES   (HR),
    .V_RES   (VR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_go   (frame_go),
    .start_X    (start_X),
    .start_Y    (start_Y),
    .zoom_level (zoom_level),
    .eng_ready  (eng_ready),
    .eng_valid  (eng_valid),
    .pix_X      (pix_X),
    .pix_Y      (pix_Y),
    .c_re       (c_re),
    .c_im       (c_im),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: which pixel is on offer, which engine may take it, and what its coordinate is.
  function automatic int pick(input int ptr, input logic [3:0] rdy);
    int r;
    r = -1;
    for (int k = 0; k < NE; k++) begin
      if (r < 0 && rdy[(ptr + k) % NE] === 1'b1) r = (ptr + k) % NE;
    end
    return r;
  endfunction

  bit          m_load   = 1'b0;
  bit          m_act    = 1'b0;
  bit          m_done   = 1'b0;
  bit          m_zeroed = 1'b0;
  int          m_n      = 0;
  int          m_rr     = 0;
  int          m_g;
  logic [31:0] m_sx = '0;
  logic [31:0] m_sy = '0;
  logic [31:0] m_st = '0;
  logic [3:0]  e_ev;
  logic [15:0] e_px;
  logic [15:0] e_py;
  logic [31:0] e_re;
  logic [31:0] e_im;

  always_comb m_g = pick(m_rr, eng_ready);

  always_comb begin
    e_ev = 4'b0000;
    if (m_act && m_g >= 0) e_ev = 4'b0001 << m_g;
    e_px = 16'(m_n % HR);
    e_py = 16'(m_n / HR);
    e_re = m_sx + m_st * 32'(m_n % HR);
    e_im = m_sy - m_st * 32'(m_n / HR);
  end

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (rst) begin
      m_load   <= 1'b0;
      m_act    <= 1'b0;
      m_n      <= 0;
      m_rr     <= 0;
      m_zeroed <= 1'b1;
    end else if (m_load) begin
      m_sx     <= start_X;
      m_sy     <= start_Y;
      m_st     <= 32'h00002000 / (32'd1 << zoom_level);
      m_load   <= 1'b0;
      m_act    <= 1'b1;
      m_n      <= 0;
      m_zeroed <= 1'b0;
    end else if (m_act) begin
      if (m_g >= 0) m_rr <= (m_g + 1) % NE;
      if (RESTART && frame_go) begin
        m_act  <= 1'b0;
        m_load <= 1'b1;
      end else if (m_g >= 0) begin
        if (m_n == NPIX - 1) begin
          m_act  <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_n <= m_n + 1;
        end
      end
    end else if (!m_done && frame_go) begin
      m_load <= 1'b1;
    end
  end

  // Per-cycle compare against the model, plus literal pins on known pixels.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_load || m_act));
      chk("frame_done", 64'(frame_done), 64'(m_done));
      chk("eng_valid", 64'(eng_valid), 64'(e_ev));
      if (m_act) begin
        chk("pix_X", 64'(pix_X), 64'(e_px));
        chk("pix_Y", 64'(pix_Y), 64'(e_py));
        chk("c_re", 64'(c_re), 64'(e_re));
        chk("c_im", 64'(c_im), 64'(e_im));
      end else if (m_zeroed) begin
        chk("idle pix_X", 64'(pix_X), 64'd0);
        chk("idle pix_Y", 64'(pix_Y), 64'd0);
        chk("idle c_re", 64'(c_re), 64'd0);
        chk("idle c_im", 64'(c_im), 64'd0);
      end
      if (test_id == 1 && m_act && m_n == 1) chk("t1 c_re(1,0)", 64'(c_re), 64'h0000_0000_ffc0_1000);
      if (test_id == 1 && m_act && m_n == 11) begin
        chk("t1 c_re(3,2)", 64'(c_re), 64'h0000_0000_ffc0_3000);
        chk("t1 c_im(3,2)", 64'(c_im), 64'h0000_0000_0025_6000);
      end
      if (test_id == 3 && m_act && m_n == 1) chk("t3 c_re(1,0)", 64'(c_re), 64'h0000_0000_8000_0400);
      if (test_id == 3 && m_act && m_n == 4) chk("t3 c_im(0,1)", 64'(c_im), 64'h0000_0000_7fff_fc00);
    end
  end

  int xfer_cnt = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (eng_valid != 4'b0000) xfer_cnt <= xfer_cnt + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  task automatic wait_done(input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("frame_done reached", 64'(ok), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  logic [3:0] evseq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int base_x;
  int base_d;

  initial begin
    rst = 1'b1; frame_go = 1'b0; start_X = '0; start_Y = '0; zoom_level = 2'd0; eng_ready = 4'hf;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1; rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset eng_valid", 64'(eng_valid), 64'd0);
    chk("reset c_re", 64'(c_re), 64'd0);

    // 1: full frame, all engines ready
    test_id = 1;
    @(posedge clk); #1 start_X = 32'hffc00000; start_Y = 32'h00258000; zoom_level = 2'd1; frame_go = 1'b1;
    @(posedge clk); #1 frame_go = 1'b0;
    @(negedge clk);
    chk("t1 load eng_valid", 64'(eng_valid), 64'd0);
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      chk("t1 grant seq", 64'(eng_valid), 64'(evseq[i % 4]));
    end
    @(negedge clk);
    chk("t1 frame_done", 64'(frame_done), 64'd1);
    chk("t1 busy after", 64'(busy), 64'd0);
    @(negedge clk);
    chk("t1 done pulse width", 64'(frame_done), 64'd0);

    // 2: single ready engine, with a 5-cycle stall
    @(posedge clk); #1 test_id = 2; eng_ready = 4'b0100; start_X = 32'h00010000; start_Y = 32'h00020000;
    zoom_level = 2'd0; frame_go = 1'b1; base_x = xfer_cnt;
    @(posedge clk); #1 frame_go = 1'b0;
    repeat (5) @(posedge clk);
    #1 eng_ready = 4'b0000;
    repeat (5) @(posedge clk);
    #1 eng_ready = 4'b0100;
    wait_done(60);
    chk("t2 transfers", 64'(xfer_cnt - base_x), 64'(NPIX));

    // 3: frame_go during DONE is ignored; the cycle after starts a new frame
    frame_go = 1'b1; test_id = 3; start_X = 32'h80000000; start_Y = 32'h80000000; zoom_level = 2'd3;
    @(posedge clk); #1 eng_ready = 4'hf; base_x = xfer_cnt;
    @(negedge clk);
    chk("t3 go in DONE ignored", 64'(busy), 64'd0);
    @(posedge clk); #1 frame_go = 1'b0;
    @(negedge clk);
    chk("t3 busy in load", 64'(busy), 64'd1);
    wait_done(40);
    chk("t3 transfers", 64'(xfer_cnt - base_x), 64'(NPIX));

    // 4: frame_go while pixel 5 is on offer
    @(posedge clk); #1 test_id = 4; start_X = 32'h00100000; start_Y = 32'hfff00000; zoom_level = 2'd0;
    frame_go = 1'b1; base_x = xfer_cnt; base_d = done_cnt;
    @(posedge clk); #1 frame_go = 1'b0;
    repeat (6) @(posedge clk);
    #1 frame_go = 1'b1; start_X = 32'h12345000; start_Y = 32'h00abc000; zoom_level = 2'd2;
    @(posedge clk); #1 frame_go = 1'b0;
    repeat (30) @(negedge clk);
    chk("t4 transfers", 64'(xfer_cnt - base_x), RESTART ? 64'd18 : 64'd12);
    chk("t4 frame_done count", 64'(done_cnt - base_d), 64'd1);

    // 5: reset mid-frame
    @(posedge clk); #1 test_id = 5; start_X = 32'h00000000; start_Y = 32'h00000000; frame_go = 1'b1;
    @(posedge clk); #1 frame_go = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5 busy after rst", 64'(busy), 64'd0);
    chk("t5 eng_valid after rst", 64'(eng_valid), 64'd0);
    @(posedge clk); #1 frame_go = 1'b1;
    @(posedge clk); #1 frame_go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5 first grant", 64'(eng_valid), 64'd1);
    chk("t5 first pix_X", 64'(pix_X), 64'd0);
    chk("t5 first pix_Y", 64'(pix_Y), 64'd0);
    wait_done(40);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
